// File: rtl/eq_sweep_checker.sv
// Exhaustive a/b sweep driver for an equality comparator; checks each aeqb response against a==b.
// Each vector is held LAT+1 cycles and sampled in the last one; no backpressure, runs free once started.
module eq_sweep_checker #(
  parameter int W   = 2,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic           aeqb_in,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_cnt,
  output logic           first_err_vld,
  output logic [W-1:0]   first_err_a,
  output logic [W-1:0]   first_err_b,
  output logic           pass
);

  localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [WW-1:0]  WLAST   = WW'(LAT);
  localparam logic [WW-1:0]  WONE    = WW'(1);
  localparam logic [2*W-1:0] IDX_ONE = (2*W)'(1);
  localparam logic [2*W:0]   ERR_ONE = (2*W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] idx;
  logic [WW-1:0]  wcnt;
  logic           smp, mis, last;

  // aeqb_in only matters on the sample cycle of each vector
  assign smp   = (state == RUN) && (wcnt == WLAST);
  assign mis   = smp && (aeqb_in != (a_out == b_out));
  assign last  = &idx;
  assign a_out = idx[2*W-1:W];
  assign b_out = idx[W-1:0];
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (smp && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      wcnt          <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      pass          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            wcnt          <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            pass          <= 1'b0;
          end
        end
        RUN: begin
          if (!smp) begin
            wcnt <= wcnt + WONE;
          end else begin
            if (mis) begin
              err_cnt <= err_cnt + ERR_ONE;
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_a   <= a_out;
                first_err_b   <= b_out;
              end
            end
            // on the last vector idx stays put so a/b rest at the all-ones pair
            if (!last) begin
              idx  <= idx + IDX_ONE;
              wcnt <= '0;
            end
          end
        end
        DONE:    pass <= (err_cnt == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Bench: two checkers (LAT=0 and LAT=2) each driving a fault-injectable comparator model.
module tb_eq_sweep_checker;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      start;
  logic [1:0][1:0] a_out, b_out, fea, feb;
  logic [1:0]      aeqb, busy, done, fev, pass;
  logic [1:0][4:0] err_cnt;
  logic [1:0][15:0] mask_r;
  logic [1:0]      reg_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_u
    logic eq0, p1, p2;
    assign eq0 = (a_out[g] == b_out[g]) ^ mask_r[g][{a_out[g], b_out[g]}];
    always @(posedge clk) begin
      p1 <= eq0;
      p2 <= p1;
    end
    assign aeqb[g] = reg_r[g] ? p2 : eq0;

    eq_sweep_checker #(.W(2), .LAT(g == 0 ? 0 : 2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start[g]),
      .a_out        (a_out[g]),
      .b_out        (b_out[g]),
      .aeqb_in      (aeqb[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .err_cnt      (err_cnt[g]),
      .first_err_vld(fev[g]),
      .first_err_a  (fea[g]),
      .first_err_b  (feb[g]),
      .pass         (pass[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] stuck_mask(input bit val);
    logic [15:0] m;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        m[a*4+b] = ((a == b) != val);
    return m;
  endfunction

  // matched: DUT delay equals checker LAT, so the exact reference applies
  task automatic sweep(input int u, input logic [15:0] mask, input logic rd,
                       input bit matched, input int repulse, input string tag);
    int n, lat, exp_err, fi, early;
    bit said;
    lat = (u == 0) ? 0 : 2;
    exp_err = 0;
    fi = -1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        said = (a == b) ^ mask[a*4+b];
        if (said != (a == b)) begin
          exp_err++;
          if (fi < 0) fi = a*4 + b;
        end
      end
    @(negedge clk);
    mask_r[u] = mask;
    reg_r[u]  = rd;
    start[u]  = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    chk({tag, ":clr"}, {err_cnt[u], fev[u], pass[u], a_out[u], b_out[u]}, 0);
    n = 0;
    early = 0;
    while (busy[u] && n < 400) begin
      if (done[u]) early++;
      start[u] = (n == repulse);
      n++;
      @(negedge clk);
    end
    start[u] = 1'b0;
    chk({tag, ":busy_len"}, n, 16 * (lat + 1));
    chk({tag, ":done_early"}, early, 0);
    chk({tag, ":done"}, done[u], 1);
    chk({tag, ":ab_end"}, {a_out[u], b_out[u]}, 4'hF);
    if (matched) begin
      chk({tag, ":err"}, err_cnt[u], exp_err);
      chk({tag, ":fev"}, fev[u], exp_err > 0);
      if (exp_err > 0) chk({tag, ":first"}, {fea[u], feb[u]}, fi);
    end else begin
      chk({tag, ":err_nz"}, err_cnt[u] != 0, 1);
    end
    @(negedge clk);
    chk({tag, ":done_off"}, done[u], 0);
    chk({tag, ":pass"}, pass[u], matched && exp_err == 0);
  endtask

  task automatic reset_mid();
    int n;
    @(negedge clk);
    mask_r[0] = stuck_mask(1'b0);
    reg_r[0]  = 1'b0;
    start[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (n < 7 && busy[0]) begin
      n++;
      @(negedge clk);
    end
    chk("rst_mid:idx", {a_out[0], b_out[0]}, 7);
    chk("rst_mid:err", err_cnt[0], 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid:outs", {a_out[0], b_out[0], busy[0], done[0], err_cnt[0],
                         fev[0], fea[0], feb[0], pass[0]}, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = '0;
    mask_r = '0;
    reg_r  = '0;
    repeat (3) @(negedge clk);
    chk("rst0", {a_out[0], b_out[0], busy[0], done[0], err_cnt[0], fev[0], fea[0], feb[0], pass[0]}, 0);
    chk("rst1", {a_out[1], b_out[1], busy[1], done[1], err_cnt[1], fev[1], fea[1], feb[1], pass[1]}, 0);
    reset = 1'b0;

    sweep(0, 16'h0000, 1'b0, 1'b1, -1, "good");
    sweep(0, stuck_mask(1'b0), 1'b0, 1'b1, -1, "stuck0");
    sweep(0, 16'h0000, 1'b0, 1'b1, -1, "fixed");
    sweep(0, stuck_mask(1'b1), 1'b0, 1'b1, -1, "stuck1");
    sweep(1, 16'h0000, 1'b1, 1'b1, -1, "lat2");
    sweep(0, 16'h0000, 1'b1, 1'b0, -1, "lat_mis");
    sweep(0, 16'h0000, 1'b0, 1'b1, 5, "repulse");

    reset_mid();

    @(negedge clk);
    reset    = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    start[0] = 1'b0;
    chk("rst_start:busy", busy[0], 0);
    @(negedge clk);
    chk("rst_start:busy2", busy[0], 0);

    sweep(0, 16'h0000, 1'b0, 1'b1, -1, "after_rst");

    for (int i = 0; i < 6; i++) begin
      int u;
      logic [15:0] m;
      u = $urandom_range(0, 1);
      m = 16'($urandom & $urandom);
      sweep(u, m, u == 1, 1'b1, -1, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
